// File: rtl/adxl362_spi_master.sv
// SPI master (CPOL=0, CPHA=0) for the ADXL362 accelerometer.
//
// Runs one transaction at a time: register write burst (0x0A), register read
// burst (0x0B) or FIFO read (0x0D). Bytes go out MSB-first. A transaction is
// CMD, then ADDR (omitted for FIFO reads), then length+1 data bytes. After the
// last bit SCLK stays low for CLK_DIV cycles before nCS rises, and nCS then
// stays high for CLK_DIV cycles before busy drops.
//
// Ports:
//   clk_16mhz  system clock, the only clock
//   reset      asynchronous active-high reset
//   start      request pulse, accepted only while busy=0
//   command    0x0A write, 0x0B read, 0x0D FIFO read
//   address    start register address, sent as {2'b00,address}
//   length     data bytes minus one
//   wr_data    next write byte, sampled in the wr_ack cycle
//   wr_ack     one-cycle pulse: wr_data consumed
//   rd_data    last received data byte
//   rd_valid   one-cycle pulse: rd_data updated
//   busy       transaction in progress, including the nCS idle gap
//   done       one-cycle pulse in the cycle nCS returns high
//   error      one-cycle pulse: start with an unsupported command
//   SCLK/MOSI/MISO/nCS  SPI pins

module adxl362_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk_16mhz,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       command,
  input  logic [5:0]       address,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       wr_data,
  output logic             wr_ack,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             nCS
);

  localparam int unsigned   CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  localparam logic [7:0] CmdWrite = 8'h0A;
  localparam logic [7:0] CmdRead  = 8'h0B;
  localparam logic [7:0] CmdFifo  = 8'h0D;

  typedef enum logic [1:0] {StIdle, StShift, StHold, StGap} state_e;
  typedef enum logic [1:0] {ByteCmd, ByteAddr, ByteData} byte_e;

  state_e           state_q, state_d;
  byte_e            byte_q, byte_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [5:0]       addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W:0]   data_cnt_q, data_cnt_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             ncs_q, ncs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic tick;
  logic high_end;
  logic byte_end;
  logic last_data;
  logic is_write;
  logic cmd_legal;

  assign tick      = (cnt_q == CntLast);
  assign high_end  = (state_q == StShift) && tick && sclk_q;
  assign byte_end  = high_end && (bit_q == 3'd7);
  assign last_data = (byte_q == ByteData) && (data_cnt_q == {1'b0, len_q});
  assign is_write  = (cmd_q == CmdWrite);
  assign cmd_legal = (command == CmdWrite) || (command == CmdRead) || (command == CmdFifo);

  // A write data byte is loaded at the end of the preceding byte; the ack marks that cycle.
  assign wr_ack = byte_end && is_write && (byte_q != ByteCmd) && !last_data;

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_cnt_d = data_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sclk_d     = sclk_q;
    ncs_d      = ncs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cmd_legal) begin
            cmd_d      = command;
            addr_d     = address;
            len_d      = length;
            tx_d       = command;
            cnt_d      = '0;
            bit_d      = 3'd0;
            sclk_d     = 1'b0;
            byte_d     = ByteCmd;
            data_cnt_d = '0;
            ncs_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = StShift;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      StShift: begin
        if (!tick) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of high half: sample MISO, drop SCLK, present the next MOSI bit.
            sclk_d = 1'b0;
            rx_d   = {rx_q[6:0], MISO};
            bit_d  = bit_q + 3'd1;
            if (bit_q != 3'd7) begin
              tx_d = {tx_q[6:0], 1'b0};
            end else begin
              if ((byte_q == ByteData) && !is_write) begin
                rd_data_d  = {rx_q[6:0], MISO};
                rd_valid_d = 1'b1;
              end
              unique case (byte_q)
                ByteCmd: begin
                  if (cmd_q == CmdFifo) begin
                    byte_d = ByteData;
                    tx_d   = 8'h00;
                  end else begin
                    byte_d = ByteAddr;
                    tx_d   = {2'b00, addr_q};
                  end
                end
                ByteAddr: begin
                  byte_d = ByteData;
                  tx_d   = is_write ? wr_data : 8'h00;
                end
                ByteData: begin
                  if (last_data) begin
                    tx_d    = 8'h00;
                    state_d = StHold;
                  end else begin
                    data_cnt_d = data_cnt_q + 1'b1;
                    tx_d       = is_write ? wr_data : 8'h00;
                  end
                end
                default: begin
                  state_d = StIdle;
                end
              endcase
            end
          end
        end
      end

      StHold: begin
        if (tick) begin
          cnt_d   = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StGap: begin
        if (tick) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_q     <= ByteCmd;
      cmd_q      <= 8'h00;
      addr_q     <= 6'h00;
      len_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      data_cnt_q <= '0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      sclk_q     <= 1'b0;
      ncs_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_cnt_q <= data_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      sclk_q     <= sclk_d;
      ncs_q      <= ncs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign SCLK     = sclk_q;
  assign MOSI     = tx_q[7];
  assign nCS      = ncs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Directed bench for adxl362_spi_master with a small ADXL362 slave model.

module tb_adxl362_spi_master;

  logic       clk_16mhz = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] command;
  logic [5:0] address;
  logic [3:0] length;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       error;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic       nCS;

  adxl362_spi_master #(
    .CLK_DIV(4),
    .LEN_W  (4)
  ) dut (
    .clk_16mhz(clk_16mhz),
    .reset    (reset),
    .start    (start),
    .command  (command),
    .address  (address),
    .length   (length),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .nCS      (nCS)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor counters, sampled on the falling clock edge.
  int         cyc = 0;
  int         ncs_low, gap_cnt, busy_cnt, done_cnt, err_cnt, wr_cnt, wr_first, wr_last;
  int         sclk_rises;
  logic [7:0] rd_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] wr_bytes[0:15];
  logic [7:0] miso_stream[0:19];

  always @(negedge clk_16mhz) begin
    cyc++;
    if (!nCS) ncs_low++;
    if (nCS && busy) gap_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (rd_valid) rd_q.push_back(rd_data);
    wr_data = (wr_cnt < 16) ? wr_bytes[wr_cnt] : 8'h00;
    if (wr_ack) begin
      if (wr_cnt == 0) wr_first = cyc;
      wr_last = cyc;
      wr_cnt++;
    end
  end

  // Slave model: captures MOSI on SCLK rise, shifts MISO out on SCLK fall.
  int         sl_bit = 0;
  logic [7:0] mosi_sh = 8'h00;
  logic [7:0] tmp_a, tmp_b;

  always @(negedge nCS) begin
    sl_bit = 0;
    tmp_a  = miso_stream[0];
    MISO   = tmp_a[7];
  end

  always @(posedge SCLK) begin
    sclk_rises++;
    mosi_sh = {mosi_sh[6:0], MOSI};
    sl_bit++;
    if (sl_bit % 8 == 0) mosi_q.push_back(mosi_sh);
  end

  always @(negedge SCLK) begin
    if (!nCS && sl_bit < 160) begin
      tmp_b = miso_stream[sl_bit / 8];
      MISO  = tmp_b[7 - (sl_bit % 8)];
    end
  end

  task automatic clear();
    ncs_low = 0; gap_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    wr_cnt = 0; wr_first = 0; wr_last = 0; sclk_rises = 0;
    rd_q.delete();
    mosi_q.delete();
  endtask

  task automatic kick(input logic [7:0] c, input logic [5:0] a, input logic [3:0] l);
    @(negedge clk_16mhz);
    start = 1'b1; command = c; address = a; length = l;
    @(negedge clk_16mhz);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk_16mhz);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk_16mhz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; command = 8'h00; address = 6'h00; length = 4'h0;
    MISO = 1'b0; wr_data = 8'h00;
    for (int i = 0; i < 16; i++) wr_bytes[i] = 8'h00;
    for (int i = 0; i < 20; i++) miso_stream[i] = 8'hFF;
    clear();
    repeat (3) @(negedge clk_16mhz);

    // Reset state
    check("rst_ncs", {31'd0, nCS}, 32'd1);
    check("rst_sclk", {31'd0, SCLK}, 32'd0);
    check("rst_mosi", {31'd0, MOSI}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {28'd0, done, error, wr_ack, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk_16mhz);

    // Single-byte write: 0x0A, 0x2D, 0x02
    clear();
    wr_bytes[0] = 8'h02;
    kick(8'h0A, 6'h2D, 4'h0);
    wait_idle(1000);
    check("wr_mosi_n", mosi_q.size(), 3);
    check("wr_mosi_cmd", {24'd0, mosi_q[0]}, 32'h0A);
    check("wr_mosi_addr", {24'd0, mosi_q[1]}, 32'h2D);
    check("wr_mosi_data", {24'd0, mosi_q[2]}, 32'h02);
    check("wr_ack_n", wr_cnt, 1);
    check("wr_ncs_low", ncs_low, 196);
    check("wr_done_n", done_cnt, 1);
    check("wr_gap", gap_cnt, 4);
    check("wr_no_rd", rd_q.size(), 0);

    // Burst read of 4 bytes, with an ignored start in the middle
    clear();
    miso_stream[0] = 8'hFF; miso_stream[1] = 8'hFF;
    miso_stream[2] = 8'hAD; miso_stream[3] = 8'h1D;
    miso_stream[4] = 8'hF2; miso_stream[5] = 8'h01;
    kick(8'h0B, 6'h00, 4'h3);
    repeat (100) @(negedge clk_16mhz);
    start = 1'b1; command = 8'h0A; address = 6'h3F; length = 4'h2;
    @(negedge clk_16mhz);
    start = 1'b0;
    wait_idle(2000);
    check("rd_n", rd_q.size(), 4);
    check("rd_0", {24'd0, rd_q[0]}, 32'hAD);
    check("rd_1", {24'd0, rd_q[1]}, 32'h1D);
    check("rd_2", {24'd0, rd_q[2]}, 32'hF2);
    check("rd_3", {24'd0, rd_q[3]}, 32'h01);
    check("rd_mosi_n", mosi_q.size(), 6);
    check("rd_mosi_cmd", {24'd0, mosi_q[0]}, 32'h0B);
    check("rd_mosi_addr", {24'd0, mosi_q[1]}, 32'h00);
    check("rd_mosi_data", {mosi_q[2], mosi_q[3], mosi_q[4], mosi_q[5]}, 32'h0);
    check("rd_ncs_low", ncs_low, 388);
    check("rd_ignored_err", err_cnt, 0);
    check("rd_no_wr_ack", wr_cnt, 0);
    check("rd_done_n", done_cnt, 1);

    // FIFO read of 2 bytes: no ADDR byte
    clear();
    miso_stream[0] = 8'hFF; miso_stream[1] = 8'h11; miso_stream[2] = 8'h22;
    kick(8'h0D, 6'h15, 4'h1);
    wait_idle(1000);
    check("fifo_mosi_n", mosi_q.size(), 3);
    check("fifo_mosi_cmd", {24'd0, mosi_q[0]}, 32'h0D);
    check("fifo_rd_n", rd_q.size(), 2);
    check("fifo_rd_0", {24'd0, rd_q[0]}, 32'h11);
    check("fifo_rd_1", {24'd0, rd_q[1]}, 32'h22);
    check("fifo_ncs_low", ncs_low, 196);

    // Unsupported command
    clear();
    kick(8'h55, 6'h01, 4'h0);
    repeat (5) @(negedge clk_16mhz);
    check("bad_err_n", err_cnt, 1);
    check("bad_ncs_low", ncs_low, 0);
    check("bad_busy", busy_cnt, 0);

    // Asynchronous reset in the middle of the ADDR byte
    clear();
    begin
      int n = 0;
      kick(8'h0B, 6'h2D, 4'h0);
      while (sclk_rises < 12 && n < 500) begin
        @(negedge clk_16mhz);
        n++;
      end
      check("mid_reached", sclk_rises, 12);
    end
    #2 reset = 1'b1;
    #1;
    check("mid_ncs", {31'd0, nCS}, 32'd1);
    check("mid_sclk", {31'd0, SCLK}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_pulses", {28'd0, done, error, wr_ack, rd_valid}, 32'd0);
    check("mid_rd_data", {24'd0, rd_data}, 32'h00);
    @(negedge clk_16mhz);
    @(negedge clk_16mhz);
    reset = 1'b0;
    clear();
    miso_stream[2] = 8'h5A;
    kick(8'h0B, 6'h05, 4'h0);
    wait_idle(1000);
    check("post_rd_n", rd_q.size(), 1);
    check("post_rd_0", {24'd0, rd_q[0]}, 32'h5A);
    check("post_mosi_addr", {24'd0, mosi_q[1]}, 32'h05);

    // Full-length write burst: 16 data bytes
    clear();
    for (int i = 0; i < 16; i++) wr_bytes[i] = 8'h30 + 8'(i);
    kick(8'h0A, 6'h20, 4'hF);
    wait_idle(3000);
    check("burst_ack_n", wr_cnt, 16);
    check("burst_ack_span", wr_last - wr_first, 15 * 64);
    check("burst_sclk_rises", sclk_rises, 144);
    check("burst_mosi_n", mosi_q.size(), 18);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("burst_data_%0d", i), {24'd0, mosi_q[2 + i]}, 32'h30 + i);
    end
    check("burst_ncs_low", ncs_low, 1156);
    check("burst_done_n", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_master.md
Name: adxl362_spi_master

Overview:
SPI master (CPOL=0, CPHA=0) that drives the ADXL362 slave interface from the FPGA side.
- Accepts one transaction request at a time: register write burst (0x0A), register read burst (0x0B) or FIFO read (0x0D).
- Serialises command, address and data bytes MSB-first on SCLK/MOSI and deserialises MISO.
- Sits between the accelerometer control logic and the PMOD pins; all logic is in the clk_16mhz domain.

Parameters:
CLK_DIV, 4, clk_16mhz cycles per SCLK half-period; must be >= 2. Default gives a 2 MHz SCLK.
LEN_W, 4, width of the length field; data bytes per transaction = length + 1.

Ports:
clk_16mhz  input  1  system clock; the only clock
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; accepted only when busy=0
command  input  8  0x0A write, 0x0B read, 0x0D FIFO read
address  input  6  start register address; transmitted as {2'b00,address}
length  input  LEN_W  number of data bytes minus 1
wr_data  input  8  next write byte; sampled in the wr_ack cycle
wr_ack  output  1  one-cycle pulse: wr_data consumed
rd_data  output  8  received data byte
rd_valid  output  1  one-cycle pulse: rd_data valid
busy  output  1  transaction in progress (includes CS idle gap)
done  output  1  one-cycle pulse when nCS returns high
error  output  1  one-cycle pulse: start with unsupported command
SCLK  output  1  SPI clock, idles low
MOSI  output  1  SPI data out
MISO  input  1  SPI data in
nCS  output  1  chip select, active low

Behaviour:
Reset, asynchronous and mid-transaction included:
- nCS=1, SCLK=0, MOSI=0, busy=0, done=0, error=0, wr_ack=0, rd_valid=0, rd_data=0x00.
- State returns to IDLE; any partial transfer is abandoned.

IDLE:
- start with a legal command: latch command, address and length; busy=1 the next cycle; go to SHIFT.
- start with any other command: error pulses 1 cycle; the request is dropped and busy stays 0.
- start while busy=1: ignored, with no error.

Byte sequence:
- 0x0A / 0x0B: CMD, ADDR, then length+1 DATA bytes.
- 0x0D: CMD, then length+1 DATA bytes; there is no ADDR byte.

SHIFT (one bit = CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high):
- nCS falls on SHIFT entry, with MOSI already holding bit7 of CMD. The first low half provides CS setup.
- MISO is sampled in the last clk_16mhz cycle of each high half.
- MOSI updates on each high-to-low SCLK transition.
- Write data byte: wr_data is loaded into the shift register in the cycle before that byte's first low half, and wr_ack pulses in that cycle. There is no stall; upstream must hold wr_data valid whenever an ack can occur.
- Read and FIFO data bytes: MOSI=0 throughout. rd_data is updated and rd_valid pulses 1 cycle after the 8th MISO sample.
- rd_valid never pulses for CMD or ADDR bytes; MISO is ignored during them.

HOLD:
- After the last high half, SCLK=0 for CLK_DIV cycles, then nCS=1 and done pulses in that cycle.

GAP:
- nCS stays high for CLK_DIV cycles, then busy=0 and the block is in IDLE.
- The earliest next start is accepted the cycle busy reads 0.

Timing and counters:
- nCS low time = 16*CLK_DIV*nbytes + CLK_DIV cycles, where nbytes is the total bytes on the wire.
- Bit counter is 3 bits and wraps 7 to 0 at each byte boundary.
- Byte counter is LEN_W+1 bits wide; length = all-ones gives 2^LEN_W data bytes with no overflow.

Test Plan:
- CLK_DIV=4, start cmd 0x0A addr 0x2D len 0, wr_data 0x02 -> MOSI stream 0x0A,0x2D,0x02; wr_ack once; nCS low exactly 196 cycles; done once; busy low 4 cycles after nCS rises.
- Read 0x0B addr 0x00 len 3, slave model returns 0xAD,0x1D,0xF2,0x01 -> 4 rd_valid pulses with those values in order; MOSI 0x00 during data bytes; no rd_valid during CMD/ADDR.
- FIFO 0x0D len 1 -> only 3 bytes framed (no ADDR byte); 2 rd_valid pulses; nCS low 3*64+4 = 196 cycles.
- start cmd 0x55 -> error pulse 1 cycle, nCS stays high, busy stays 0; start during an active read -> ignored, current transfer completes unchanged.
- Assert reset mid-ADDR byte -> nCS=1 and SCLK=0 in the same cycle, all pulses 0; a following 0x0B transaction completes correctly.
- len = all-ones (16 data bytes) write burst -> 16 wr_ack pulses spaced 64 cycles apart; SCLK shows 144 rising edges in total.
